instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read port. Generates word addresses into `InstructionMemory`, captures the returned instruction words, and buffers them in a 2-entry queue. Delivers each instruction with its PC to the decode stage over a valid/ready handshake, at a sustained rate of one instruction per cycle. A redirect input (branch or jump) flushes the queue and restarts fetch at a new PC.

---
 rtl/instruction_fetch_unit_if.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-fetch bus: memory read port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, fetch_count,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, fetch_count,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word addresses to InstructionMemory, captures
// responses into a 2-entry {instr, pc} queue and hands them to decode.
// Optional accepted-instruction counter enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_fetch_unit_if.master ifu
);
    logic [31:0] r_fetch_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;
    logic [1:0]  r_occ;
    logic [31:0] r_head_instr, r_head_pc;
    logic [31:0] r_tail_instr, r_tail_pc;

    logic        w_pop, w_push, w_issue;
    logic [2:0]  w_credit;

    // Credit rule: buffered + in-flight entries after this cycle's pop must stay
    // below 2, so a response always has a free slot when it lands.
    assign w_pop    = (r_occ != 2'd0) & ifu.id_ready;
    assign w_push   = r_pend & !ifu.redirect_valid;
    assign w_credit = {1'b0, r_occ} + {2'b00, r_pend};
    assign w_issue  = !ifu.redirect_valid & (w_credit < (3'd2 + {2'b00, w_pop}));

    // Fetch PC and the single outstanding request; redirect kills the in-flight one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_pc  <= '0;
        end else if (ifu.redirect_valid) begin
            r_fetch_pc <= ifu.redirect_pc;
            r_pend     <= 1'b0;
        end else if (w_issue) begin
            r_pend     <= 1'b1;
            r_pend_pc  <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_INC;
        end else begin
            r_pend     <= 1'b0;
        end
    end

    // Two-entry queue as head/tail registers; head stays put when the queue empties
    // so decode sees the last delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ        <= 2'd0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
            r_tail_instr <= '0;
            r_tail_pc    <= '0;
        end else if (ifu.redirect_valid) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_instr <= ifu.imem_data;
                        r_head_pc    <= r_pend_pc;
                    end else begin
                        r_tail_instr <= ifu.imem_data;
                        r_tail_pc    <= r_pend_pc;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head_instr <= r_tail_instr;
                        r_head_pc    <= r_tail_pc;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head_instr <= ifu.imem_data;
                        r_head_pc    <= r_pend_pc;
                    end else begin
                        r_head_instr <= r_tail_instr;
                        r_head_pc    <= r_tail_pc;
                        r_tail_instr <= ifu.imem_data;
                        r_tail_pc    <= r_pend_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Count every delivered instruction, redirect cycles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fetch_count <= '0;
        else if (w_pop)
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign ifu.fetch_count = r_fetch_count;
`else
    assign ifu.fetch_count = 32'd0;
`endif

    assign ifu.imem_addr = r_fetch_pc;
    assign ifu.id_valid  = (r_occ != 2'd0);
    assign ifu.id_instr  = r_head_instr;
    assign ifu.id_pc     = r_head_pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven cycle vectors for streaming,
// backpressure and redirects, then hand sequences for async reset and PC wrap.
module tb_instruction_fetch_unit;
    logic clk;
    logic rst_n;
    logic rst_n_b;

    instruction_fetch_unit_if ifa();
    instruction_fetch_unit_if ifb();

    instruction_fetch_unit #(.RESET_PC(32'h0), .PC_INC(32'd1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ifu(ifa.master)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .PC_INC(32'd1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .ifu(ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word i holds 0x1000 + i, data valid the cycle after the address.
    always @(posedge clk) begin
        ifa.imem_data <= 32'h1000 + ifa.imem_addr;
        ifb.imem_data <= 32'h1000 + ifb.imem_addr;
    end

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [33];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   hcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_row(input int k, input logic r, input logic rv, input logic [31:0] rpc,
                           input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
        tbl[k].ready  = r;
        tbl[k].rv     = rv;
        tbl[k].rpc    = rpc;
        tbl[k].ev     = ev;
        tbl[k].epc    = epc;
        tbl[k].einstr = (k < 2) ? 32'h0 : 32'h1000 + epc;
        tbl[k].eaddr  = eaddr;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef IFU_PERF_CNT_EN
        return n;
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    initial begin
        // cycle: ready, redirect, redirect_pc, exp valid, exp pc, exp addr
        set_row(0, 1, 0, 0, 0, 0, 0);
        set_row(1, 1, 0, 0, 0, 0, 1);
        set_row(2, 1, 0, 0, 1, 0, 2);
        for (int k = 3; k <= 10; k++) set_row(k, 0, 0, 0, 1, 1, 3);
        set_row(11, 1, 0, 0, 1, 1, 3);
        for (int k = 12; k <= 15; k++) set_row(k, 1, 0, 0, 1, k - 10, k - 8);
        set_row(16, 1, 1, 20, 1, 6, 8);
        set_row(17, 1, 0, 0, 0, 6, 20);
        set_row(18, 1, 0, 0, 0, 6, 21);
        for (int k = 19; k <= 21; k++) set_row(k, 1, 0, 0, 1, k + 1, k + 3);
        set_row(22, 0, 0, 0, 1, 23, 25);
        set_row(23, 0, 0, 0, 1, 23, 25);
        set_row(24, 0, 1, 5, 1, 23, 25);
        set_row(25, 0, 0, 0, 0, 23, 5);
        set_row(26, 0, 0, 0, 0, 23, 6);
        set_row(27, 0, 0, 0, 1, 5, 7);
        set_row(28, 1, 0, 0, 1, 5, 7);
        set_row(29, 1, 0, 0, 1, 6, 8);
        set_row(30, 1, 0, 0, 1, 7, 9);
        set_row(31, 0, 0, 0, 1, 8, 10);
        set_row(32, 0, 0, 0, 1, 8, 10);

        rst_n = 1'b0;
        rst_n_b = 1'b0;
        ifa.id_ready = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0;
        ifb.id_ready = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0;
        repeat (3) @(negedge clk);

        chk("reset id_valid", {31'd0, ifa.id_valid}, 32'd0);
        chk("reset imem_addr", ifa.imem_addr, 32'd0);
        chk("reset id_instr", ifa.id_instr, 32'd0);
        chk("reset id_pc", ifa.id_pc, 32'd0);
        chk("reset fetch_count", ifa.fetch_count, 32'd0);
        chk("reset B imem_addr", ifb.imem_addr, 32'hFFFF_FFFE);

        rst_n = 1'b1;
        for (int k = 0; k < 33; k++) begin
            chk($sformatf("c%0d id_valid", k), {31'd0, ifa.id_valid}, {31'd0, tbl[k].ev});
            chk($sformatf("c%0d id_pc", k), ifa.id_pc, tbl[k].epc);
            chk($sformatf("c%0d id_instr", k), ifa.id_instr, tbl[k].einstr);
            chk($sformatf("c%0d imem_addr", k), ifa.imem_addr, tbl[k].eaddr);
            ifa.id_ready       = tbl[k].ready;
            ifa.redirect_valid = tbl[k].rv;
            ifa.redirect_pc    = tbl[k].rpc;
            if (tbl[k].ev && tbl[k].ready) hcount++;
            @(negedge clk);
        end
        chk("stream fetch_count", ifa.fetch_count, exp_cnt(hcount));
        chk("full before reset id_pc", ifa.id_pc, 32'd8);

        // Asynchronous reset between edges while the queue is full.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst id_valid", {31'd0, ifa.id_valid}, 32'd0);
        chk("async rst imem_addr", ifa.imem_addr, 32'd0);
        chk("async rst id_pc", ifa.id_pc, 32'd0);
        chk("async rst fetch_count", ifa.fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifa.id_ready = 1'b1;
        ifa.redirect_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("restart c%0d imem_addr", c), ifa.imem_addr, c);
            chk($sformatf("restart c%0d id_valid", c), {31'd0, ifa.id_valid}, (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("restart c%0d id_pc", c), ifa.id_pc, c - 2);
                chk($sformatf("restart c%0d id_instr", c), ifa.id_instr, 32'h1000 + c - 2);
            end
            @(negedge clk);
        end

        // PC wrap on the second instance.
        rst_n_b = 1'b1;
        ifb.id_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("wrap c%0d imem_addr", c), ifb.imem_addr, 32'hFFFF_FFFE + c);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("wrap c%0d id_valid", c), {31'd0, ifb.id_valid}, 32'd1);
                chk($sformatf("wrap c%0d id_pc", c), ifb.id_pc, 32'hFFFF_FFFE + c - 2);
                chk($sformatf("wrap c%0d id_instr", c), ifb.id_instr, 32'h1000 + 32'hFFFF_FFFE + c - 2);
            end
            if (c == 2) chk("wrap fetch_count start", ifb.fetch_count, 32'd0);
            if (c == 5) chk("wrap fetch_count", ifb.fetch_count, exp_cnt(3));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
